// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor; master issues start/a/b,
// slave returns the handshake status and the registered result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff, borrow_out, ovf
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, borrow_out, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one full-subtractor cell; result registers WIDTH edges after accept.
// start is honoured only while ready (IDLE/DONE); it is ignored during RUN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic               brw_q, brw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_out_q, borrow_out_d;
  logic               ovf_q, ovf_d;

  // Full-subtractor cell from gate primitives only.
  logic a_bit, b_bit, ab_x, ab_xn, a_n, gen_brw, prop_brw, d_bit, brw_n;
  assign a_bit    = a_sh_q[0];
  assign b_bit    = b_sh_q[0];
  assign ab_x     = a_bit ^ b_bit;
  assign ab_xn    = ~ab_x;
  assign a_n      = ~a_bit;
  assign gen_brw  = a_n & b_bit;
  assign prop_brw = ab_xn & brw_q;
  assign d_bit    = ab_x ^ brw_q;
  assign brw_n    = gen_brw | prop_brw;

  logic last_bit;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_sh_d     = res_sh_q;
    brw_d        = brw_q;
    cnt_d        = cnt_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    ovf_d        = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {d_bit, res_sh_q[WIDTH-1:1]};
        brw_d    = brw_n;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // Signed overflow only when operand signs differ and the result sign leaves a's.
          diff_d       = {d_bit, res_sh_q[WIDTH-1:1]};
          borrow_out_d = brw_n;
          ovf_d        = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
          cnt_d        = '0;
          state_d      = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_sh_q     <= '0;
      brw_q        <= 1'b0;
      cnt_q        <= '0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_sh_q     <= res_sh_d;
      brw_q        <= brw_d;
      cnt_q        <= cnt_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.ready      = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.busy       = (state_q == S_RUN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboarded bench for serial_subtractor: directed corner cases, then a random sweep
// checked against an arithmetic reference model.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();
  serial_subtractor #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  exp_t held;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t mk(input logic [7:0] d, input logic bo, input logic ov);
    exp_t e;
    e.d  = d;
    e.bo = bo;
    e.ov = ov;
    return e;
  endfunction

  // Reference: modular difference, unsigned compare, signed range test.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ud;
    int sd;
    ud   = int'(a) - int'(b);
    sd   = int'($signed(a)) - int'($signed(b));
    e.d  = 8'(ud & 255);
    e.bo = (a < b);
    e.ov = (sd > 127) || (sd < -128);
    return e;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      chk1("sb_nonempty", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk8("diff", bus.diff, e.d);
        chk1("borrow_out", bus.borrow_out, e.bo);
        chk1("ovf", bus.ovf, e.ov);
      end
    end
  end

  task automatic reset_chk(input string tag);
    chk1({tag, "_ready"}, bus.ready, 1'b1);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chk1({tag, "_done"}, bus.done, 1'b0);
    chk8({tag, "_diff"}, bus.diff, 8'h00);
    chk1({tag, "_borrow"}, bus.borrow_out, 1'b0);
    chk1({tag, "_ovf"}, bus.ovf, 1'b0);
  endtask

  // Called at a negedge; returns just after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    int w;
    w = 0;
    while (!bus.ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk1("ready_before_start", bus.ready, 1'b1);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    cur       = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
  endtask

  // Walks the RUN cycles and stops at the negedge inside the DONE cycle.
  task automatic wait_run(input bit inject);
    for (int k = 1; k <= WIDTH; k++) begin
      @(negedge clk);
      chk1("busy_run", bus.busy, 1'b1);
      chk1("ready_run", bus.ready, 1'b0);
      chk1("done_run", bus.done, 1'b0);
      chk8("diff_held", bus.diff, held.d);
      chk1("borrow_held", bus.borrow_out, held.bo);
      chk1("ovf_held", bus.ovf, held.ov);
      if (inject && k == 3) begin
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
      end
      if (inject && k == 4) bus.start = 1'b0;
    end
    @(negedge clk);
    chk1("done_latency", bus.done, 1'b1);
    chk1("busy_done", bus.busy, 1'b0);
    held = cur;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    held      = mk(8'h00, 1'b0, 1'b0);
    cur       = held;
    #2;
    reset_chk("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(8'h5A, 8'h3C, mk(8'h1E, 1'b0, 1'b0)); wait_run(1'b0);
    @(negedge clk);
    start_op(8'h00, 8'h01, mk(8'hFF, 1'b1, 1'b0)); wait_run(1'b0);
    @(negedge clk);
    start_op(8'h80, 8'h01, mk(8'h7F, 1'b0, 1'b1)); wait_run(1'b0);
    @(negedge clk);
    start_op(8'h7F, 8'hFF, mk(8'h80, 1'b1, 1'b1)); wait_run(1'b0);
    @(negedge clk);
    start_op(8'h10, 8'h01, mk(8'h0F, 1'b0, 1'b0)); wait_run(1'b1);
    // Back-to-back: issue from inside the DONE cycle.
    start_op(8'h03, 8'h05, mk(8'hFE, 1'b1, 1'b0)); wait_run(1'b0);

    @(negedge clk);
    start_op(8'hAA, 8'h55, model(8'hAA, 8'h55));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_chk("midrun_rst");
    sb_q.delete();
    held = mk(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(8'h22, 8'h11, mk(8'h11, 1'b0, 1'b0)); wait_run(1'b0);

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      ra = 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? ra : 8'($urandom);
      start_op(ra, rb, model(ra, rb));
      wait_run(1'b0);
    end

    repeat (3) @(negedge clk);
    chk1("sb_drained", sb_q.size() == 0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
